// File: rtl/atree_accum_ctrl.sv
// rtl/atree_accum_ctrl.sv - chunked vector reduction through a combinational adder tree

module atree #(
   parameter int IN_WIDTH = 8,
   parameter int LEVELS   = 2
) (
   input  logic [(2**LEVELS)*IN_WIDTH-1:0] inputs,
   output logic [IN_WIDTH+LEVELS-1:0]      out
);
   localparam int N     = 2**LEVELS;
   localparam int OUT_W = IN_WIDTH + LEVELS;

   logic [OUT_W-1:0] node [N];

   // Pairwise reduction done in place: node[i] only reads indices >= i that are still untouched.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         node[i] = OUT_W'(inputs[i*IN_WIDTH +: IN_WIDTH]);
      end
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = 0; i < (N >> (l + 1)); i++) begin
            node[i] = node[2*i] + node[2*i+1];
         end
      end
      out = node[0];
   end
endmodule

module atree_accum_ctrl #(
   parameter int IN_WIDTH   = 8,
   parameter int LEVELS     = 2,
   parameter int MAX_CHUNKS = 16,
   parameter int CNT_W      = $clog2(MAX_CHUNKS+1),
   parameter int ACC_WIDTH  = IN_WIDTH + LEVELS + $clog2(MAX_CHUNKS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [CNT_W-1:0]                num_chunks,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [(2**LEVELS)*IN_WIDTH-1:0] in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [ACC_WIDTH-1:0]            sum,
   output logic                            busy
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t                      state, state_nx;
   logic [CNT_W-1:0]            remaining;
   logic [CNT_W-1:0]            load_cnt;
   logic [IN_WIDTH+LEVELS-1:0]  tree_out;
   logic                        beat;

   atree #(.IN_WIDTH(IN_WIDTH), .LEVELS(LEVELS)) u_atree (
      .inputs (in_data),
      .out    (tree_out)
   );

   assign load_cnt = (num_chunks > CNT_W'(MAX_CHUNKS)) ? CNT_W'(MAX_CHUNKS) : num_chunks;
   assign beat     = in_valid && in_ready;

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start) state_nx = (load_cnt == '0) ? DONE : ACCUM;
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && remaining == CNT_W'(1)) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sum       <= '0;
         remaining <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) begin
            sum       <= '0;
            remaining <= load_cnt;
         end else if (beat) begin
            sum       <= sum + ACC_WIDTH'(tree_out);
            remaining <= remaining - CNT_W'(1);
         end
      end
   end
endmodule

// File: doc/atree_accum_ctrl.md
# atree_accum_ctrl

Sequencing controller that reduces a long unsigned vector with the combinational adder tree (`atree`). It accepts a job of N chunks, each chunk being 2^LEVELS elements of IN_WIDTH bits. It feeds one chunk per cycle through an internal `atree` instance and accumulates the tree outputs into a wide register. It presents the final sum on a valid/ready output, and sits between a streaming producer and downstream reduction consumers.

## Interface
- IN_WIDTH, 8, width of one unsigned element.
- LEVELS, 2, adder-tree depth; chunk holds 2^LEVELS elements.
- MAX_CHUNKS, 16, largest supported chunk count per job.
- CNT_W, $clog2(MAX_CHUNKS+1), derived width of the chunk counter.
- ACC_WIDTH, IN_WIDTH+LEVELS+$clog2(MAX_CHUNKS), derived accumulator width; overflow-free for any legal job.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- num_chunks  in  CNT_W  chunk count for the job, captured with start.
- in_valid  in  1  chunk present on in_data.
- in_ready  out  1  controller accepts a chunk this cycle.
- in_data  in  2^LEVELS*IN_WIDTH  packed chunk; element 0 in the LSBs; feeds `atree.inputs`.
- out_valid  out  1  sum is final.
- out_ready  in  1  consumer accepts the sum.
- sum  out  ACC_WIDTH  accumulator register.
- busy  out  1  high whenever state != IDLE.

## Operation
- States: IDLE, ACCUM, DONE.
- **IDLE:**
  - in_ready=0 and out_valid=0.
  - When start=1, the controller clears the accumulator and loads the remaining count from num_chunks.
  - num_chunks > MAX_CHUNKS saturates to MAX_CHUNKS.
  - If the loaded count is 0, next state is DONE; otherwise next state is ACCUM.
- **ACCUM:**
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - On each accepted beat: acc <= acc + zero-extend(atree.out) and remaining <= remaining-1.
  - When the last beat is accepted (remaining==1), next state is DONE.
  - in_valid=0 simply stalls; there is no timeout.
- **DONE:**
  - out_valid=1; sum is stable.
  - When out_ready=1, next state is IDLE and the accumulator is not cleared.
- start is ignored outside IDLE, including the cycle DONE retires.
- All arithmetic is unsigned, with zero-extension from IN_WIDTH+LEVELS to ACC_WIDTH. There is no wrap for legal jobs.
- in_data is don't-care whenever in_ready=0 or in_valid=0; it must not affect sum.

## Timing
- **Reset values** (rst_n low, asynchronous):
  - State = IDLE.
  - sum=0, remaining=0.
  - in_ready=0, out_valid=0, busy=0.
- **Reset mid-job:** rst_n asserted in ACCUM or DONE aborts immediately. Partial sums are discarded, and the next job starts clean.
- **Start to ready:** start accepted at edge t gives in_ready=1 and busy=1 from cycle t+1.
- **Zero-chunk job:** out_valid=1 from cycle t+1.
- **Throughput:** one chunk per cycle with in_valid held high. A job of N chunks finishes with out_valid rising the cycle after the N-th accept, so latency from start to out_valid is N+1 cycles minimum.
- **Output hold:** out_valid and sum are held indefinitely while out_ready=0. Retiring requires out_valid && out_ready at an edge; out_valid drops the next cycle.
- **Back-to-back jobs:** the earliest next start is the cycle after retirement, i.e. one idle cycle minimum between jobs.
- **Combinational paths:** in_ready and out_valid are functions of state only. No combinational path from in_valid or out_ready to any output.

## Test plan
- **Reset:** hold rst_n=0 with random inputs -> in_ready=0, out_valid=0, busy=0, sum=0. Release -> stays IDLE with start=0.
- **Single chunk:** LEVELS=2, start with num_chunks=1, one chunk {65,42,37,9} -> in_ready high the cycle after start. out_valid the cycle after the accept with sum=153.
- **Full-scale job:** num_chunks=16, every element 0xFF, in_valid continuous -> out_valid exactly 17 cycles after start, sum=16320 (0x3FC0), no overflow.
- **Stalls and backpressure:** num_chunks=3, chunks {1,2,3,4}, {10,20,30,40}, {100,0,0,0} with 2-cycle in_valid gaps; out_ready held low 5 cycles and start pulsed during DONE -> sum=210 stable, out_valid held, extra start ignored. The controller retires on out_ready.
- **Zero and saturation:** num_chunks=0 -> out_valid the next cycle, sum=0. num_chunks=17 (CNT_W=5) -> exactly 16 chunks accepted.
- **Abort by reset:** num_chunks=4 with 2 chunks {1,1,1,1} accepted, then rst_n pulsed low -> outputs immediately at reset values. A new 1-chunk job {2,2,2,2} then yields sum=8.
